// File: rtl/alu_pipe_addsub_if.sv
// Operand/result bus for alu_pipe_addsub.
//   in_valid/in_ready : operand beat handshake (producer -> ALU)
//   a, b              : operands, WIDTH bits
//   op                : 00 ADD, 01 SUB, 10 ADC, 11 SBC
//   cin               : carry-in for ADC/SBC
//   out_valid/out_ready : result beat handshake (ALU -> consumer)
//   s                 : result, WIDTH bits
//   flags             : {N, Z, C, V}
// master = the side that feeds operands and consumes results,
// slave  = the ALU.
interface alu_pipe_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic [3:0]       flags;

    modport master (
        output in_valid, a, b, op, cin, out_ready,
        input  in_ready, out_valid, s, flags
    );

    modport slave (
        input  in_valid, a, b, op, cin, out_ready,
        output in_ready, out_valid, s, flags
    );
endinterface

// File: rtl/alu_pipe_addsub.sv
// Pipelined add/subtract unit with ready/valid handshakes on both sides.
// The WIDTH-bit add is split into STAGES slices; each stage adds one slice
// with GROUP-bit carry-lookahead units (ripple between groups) and hands its
// carry, the still-pending upper operand bits and the finished lower sum
// bits to the next stage.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset (clears valids, s and flags)
//   io  : alu_pipe_addsub_if.slave (operands, op, cin, result, flags,
//         in_valid/in_ready, out_valid/out_ready)
module alu_pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    alu_pipe_addsub_if.slave   io
);
    localparam int SW  = WIDTH / STAGES;
    localparam int NG  = SW / GROUP;
    // Pending-operand storage shrinks by SW bits per stage, finished-sum
    // storage grows by SW bits per stage; both are packed flat.
    localparam int OPW = (STAGES > 1) ? ((STAGES-1)*WIDTH - SW*(STAGES-1)*STAGES/2) : 1;
    localparam int SMW = (STAGES > 1) ? (SW*(STAGES-1)*STAGES/2) : 1;
    localparam int CW  = (STAGES > 1) ? (STAGES-1) : 1;

    // One SW-bit slice: GROUP-bit lookahead units, ripple between groups.
    // Returns {carry_out, sum}.
    function automatic logic [SW:0] slice_add(input logic [SW-1:0] x,
                                              input logic [SW-1:0] y,
                                              input logic          ci);
        logic [SW:0]   c;
        logic [SW-1:0] g;
        logic [SW-1:0] p;
        logic          acc;
        logic          pp;
        g    = x & y;
        p    = x | y;
        c    = '0;
        c[0] = ci;
        for (int gi = 0; gi < NG; gi++) begin
            // every carry inside the group is formed from the group carry-in
            for (int j = 1; j <= GROUP; j++) begin
                acc = 1'b0;
                pp  = 1'b1;
                for (int m = j - 1; m >= 0; m--) begin
                    acc = acc | (g[gi*GROUP+m] & pp);
                    pp  = pp & p[gi*GROUP+m];
                end
                c[gi*GROUP+j] = acc | (pp & c[gi*GROUP]);
            end
        end
        return {c[SW], x ^ y ^ c[SW-1:0]};
    endfunction

    // {N, Z, C, V}; cm is the carry into the MSB.
    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] sv,
                                            input logic             co,
                                            input logic             cm);
        return {sv[WIDTH-1], (sv == '0), co, cm ^ co};
    endfunction

    logic              adv;
    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] vld_nxt;
    logic [OPW-1:0]    a_p, a_nxt;
    logic [OPW-1:0]    b_p, b_nxt;
    logic [SMW-1:0]    sum_p, sum_nxt;
    logic [CW-1:0]     c_p, c_nxt;
    logic [WIDTH-1:0]  s_p, s_nxt;
    logic [3:0]        flags_p, flags_nxt;
    logic [WIDTH-1:0]  bx;
    logic              c0;

    // A full output register that is not being taken freezes the whole pipe.
    assign adv          = !vld_p[STAGES-1] || io.out_ready;
    assign io.in_ready  = adv;
    assign io.out_valid = vld_p[STAGES-1];
    assign io.s         = s_p;
    assign io.flags     = flags_p;

    assign bx = io.op[0] ? ~io.b : io.b;
    assign c0 = io.op[1] ? io.cin : io.op[0];

    if (STAGES == 1) begin : g_vld_one
        assign vld_nxt = io.in_valid;
    end else begin : g_vld_many
        assign vld_nxt = {vld_p[STAGES-2:0], io.in_valid};
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW-1:0] x_a;
        logic [SW-1:0] x_b;
        logic          x_c;
        logic [SW:0]   r;

        assign r = slice_add(x_a, x_b, x_c);

        if (k == 0) begin : g_first
            assign x_a = io.a[SW-1:0];
            assign x_b = bx[SW-1:0];
            assign x_c = c0;
            if (STAGES > 1) begin : g_fwd
                localparam int REM = WIDTH - SW;
                assign a_nxt[0 +: REM]  = io.a[WIDTH-1:SW];
                assign b_nxt[0 +: REM]  = bx[WIDTH-1:SW];
                assign sum_nxt[0 +: SW] = r[SW-1:0];
                assign c_nxt[0]         = r[SW];
            end else begin : g_last
                assign s_nxt     = r[SW-1:0];
                assign flags_nxt = mk_flags(s_nxt, r[SW], x_a[SW-1] ^ x_b[SW-1] ^ r[SW-1]);
            end
        end else begin : g_rest
            localparam int POFFO = (k-1)*WIDTH - SW*(k-1)*k/2;
            localparam int POFFS = SW*(k-1)*k/2;
            assign x_a = a_p[POFFO +: SW];
            assign x_b = b_p[POFFO +: SW];
            assign x_c = c_p[k-1];
            if (k < STAGES - 1) begin : g_fwd
                localparam int REM  = WIDTH - (k+1)*SW;
                localparam int OFFO = k*WIDTH - SW*k*(k+1)/2;
                localparam int OFFS = SW*k*(k+1)/2;
                assign a_nxt[OFFO +: REM]          = a_p[POFFO+SW +: REM];
                assign b_nxt[OFFO +: REM]          = b_p[POFFO+SW +: REM];
                assign sum_nxt[OFFS +: (k+1)*SW]   = {r[SW-1:0], sum_p[POFFS +: k*SW]};
                assign c_nxt[k]                    = r[SW];
            end else begin : g_last
                assign s_nxt     = {r[SW-1:0], sum_p[POFFS +: k*SW]};
                assign flags_nxt = mk_flags(s_nxt, r[SW], x_a[SW-1] ^ x_b[SW-1] ^ r[SW-1]);
            end
        end
    end

    // ---- stage boundary: control and visible result registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p   <= '0;
            s_p     <= '0;
            flags_p <= '0;
        end else if (adv) begin
            vld_p <= vld_nxt;
            // bubbles leave the last result in place
            if (vld_nxt[STAGES-1]) begin
                s_p     <= s_nxt;
                flags_p <= flags_nxt;
            end
        end
    end

    // ---- stage boundary: inter-stage datapath registers ----
    always_ff @(posedge clk) begin
        if (adv) begin
            a_p   <= a_nxt;
            b_p   <= b_nxt;
            sum_p <= sum_nxt;
            c_p   <= c_nxt;
        end
    end
endmodule

// File: tb/tb_alu_pipe_addsub.sv
module tb_alu_pipe_addsub;
    localparam int WIDTH  = 32;
    localparam int STAGES = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [31:0] va [128];
    logic [31:0] vb [128];
    logic [1:0]  vop[128];
    logic        vcin[128];
    logic [31:0] ms [128];
    logic [3:0]  mf [128];

    alu_pipe_addsub_if #(.WIDTH(WIDTH)) io();

    alu_pipe_addsub #(.WIDTH(WIDTH), .GROUP(4), .STAGES(STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference arithmetic: plain wide addition, signed overflow from operand signs.
    function automatic void ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                      input logic ci, output logic [31:0] rs, output logic [3:0] rf);
        logic [31:0] yy;
        logic [32:0] t;
        logic        cc;
        yy = o[0] ? ~y : y;
        cc = o[1] ? ci : o[0];
        t  = {1'b0, x} + {1'b0, yy} + {32'b0, cc};
        rs = t[31:0];
        rf = {rs[31], rs == 32'd0, t[32], (x[31] == yy[31]) && (rs[31] != x[31])};
    endfunction

    // Single beat on an idle pipe; entered and left at posedge+1.
    task automatic run1(input string tag, input logic [1:0] op_i, input logic [31:0] a_i,
                        input logic [31:0] b_i, input logic cin_i,
                        input logic [31:0] es, input logic [3:0] ef);
        int lat;
        io.in_valid  = 1'b1;
        io.a         = a_i;
        io.b         = b_i;
        io.op        = op_i;
        io.cin       = cin_i;
        io.out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, io.in_ready, 1);
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        lat = 0;
        while (!io.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, STAGES - 1);
        chk({tag, "_s"}, io.s, es);
        chk({tag, "_flags"}, io.flags, ef);
        @(posedge clk); #1;
    endtask

    // Streams n beats from va/vb/vop/vcin, expects ms/mf in order.
    // stall_len > 0: hold out_ready low that many cycles once the first result shows.
    task automatic run_stream(input string tag, input int n, input int stall_len);
        int sent, got, cyc, stall_left, first_cyc, last_cyc, rdy_lo, extra;
        bit seen;
        sent = 0; got = 0; cyc = 0; stall_left = 0; seen = 0;
        first_cyc = 0; last_cyc = 0; rdy_lo = 0; extra = 0;
        while (got < n && cyc < n + 50) begin
            if (io.out_valid && !seen) begin
                seen       = 1;
                stall_left = stall_len;
                first_cyc  = cyc;
            end
            io.out_ready = (stall_left == 0);
            io.in_valid  = (sent < n);
            if (sent < n) begin
                io.a   = va[sent];
                io.b   = vb[sent];
                io.op  = vop[sent];
                io.cin = vcin[sent];
            end
            #1;
            if (stall_left > 0) begin
                chk({tag, "_stall_s"}, io.s, ms[0]);
                chk({tag, "_stall_in_ready"}, io.in_ready, 0);
                stall_left--;
            end else if (sent < n && !io.in_ready) begin
                rdy_lo++;
            end
            if (io.out_valid && io.out_ready) begin
                chk({tag, "_s"}, io.s, ms[got]);
                chk({tag, "_flags"}, io.flags, mf[got]);
                got++;
                last_cyc = cyc;
            end
            if (io.in_valid && io.in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_count"}, got, n);
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        repeat (4) begin
            if (io.out_valid) extra++;
            @(posedge clk); #1;
        end
        chk({tag, "_no_extra"}, extra, 0);
        if (stall_len == 0) begin
            chk({tag, "_back_to_back"}, last_cyc - first_cyc, n - 1);
            chk({tag, "_in_ready_lo"}, rdy_lo, 0);
        end
    endtask

    initial begin
        int seen_after;
        io.in_valid  = 1'b0;
        io.a         = '0;
        io.b         = '0;
        io.op        = 2'b00;
        io.cin       = 1'b0;
        io.out_ready = 1'b1;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_valid", io.out_valid, 0);
        chk("reset_in_ready", io.in_ready, 1);
        chk("reset_s", io.s, 0);
        chk("reset_flags", io.flags, 0);

        // directed arithmetic, flags = {N,Z,C,V}
        run1("add_wrap",   2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b0110);
        run1("sub_ovf",    2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 4'b0011);
        run1("sub_borrow", 2'b01, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 4'b1000);
        run1("adc_xslice", 2'b10, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 32'h0001_0000, 4'b0000);
        run1("sbc",        2'b11, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0001, 4'b0010);
        run1("add_ovf",    2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b1001);
        run1("sub_zero",   2'b01, 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 4'b0110);
        run1("adc_cin0",   2'b10, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 4'b0000);

        // backpressure: 1+1..4+4, stall 3 cycles at the first result
        for (int i = 0; i < 4; i++) begin
            va[i] = i + 1; vb[i] = i + 1; vop[i] = 2'b00; vcin[i] = 1'b0;
            ms[i] = 2 * (i + 1); mf[i] = 4'b0000;
        end
        run_stream("bp", 4, 3);

        // full throughput, random beats
        for (int i = 0; i < 100; i++) begin
            va[i]   = $urandom;
            vb[i]   = $urandom;
            vop[i]  = 2'($urandom_range(0, 3));
            vcin[i] = 1'($urandom_range(0, 1));
            ref_model(vop[i], va[i], vb[i], vcin[i], ms[i], mf[i]);
        end
        run_stream("tput", 100, 0);

        // reset with two beats in flight, offered beat during reset ignored
        io.out_ready = 1'b0;
        io.in_valid  = 1'b1;
        io.op = 2'b00; io.cin = 1'b0; io.a = 32'd1; io.b = 32'd1;
        @(posedge clk); #1;
        io.a = 32'd2; io.b = 32'd2;
        @(posedge clk); #1;
        rst = 1'b1;
        io.a = 32'd100; io.b = 32'd100;
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        io.in_valid = 1'b0;
        chk("rst_mid_out_valid", io.out_valid, 0);
        chk("rst_mid_in_ready", io.in_ready, 1);
        chk("rst_mid_s", io.s, 0);
        chk("rst_mid_flags", io.flags, 0);
        seen_after = 0;
        repeat (6) begin
            if (io.out_valid) seen_after++;
            @(posedge clk); #1;
        end
        chk("rst_mid_flushed", seen_after, 0);
        run1("after_rst", 2'b00, 32'd7, 32'd8, 1'b0, 32'd15, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
